// File: rtl/ioctl_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ioctl_loader : packs HPS ioctl byte stream into DW-bit words per channel |
// | Option: LOADER_CSUM_EN enables ldr_csum byte sum.   Revision: 1.0        |
// +--------------------------------------------------------------------------+
module ioctl_loader #(
  parameter int DW      = 16,
  parameter int AW      = 20,
  parameter int NCH     = 2,
  parameter int CH_BASE = 0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [NCH-1:0]    ldr_wr,
  output logic [AW-1:0]     ldr_addr,
  output logic [DW-1:0]     ldr_wdat,
  output logic [DW/8-1:0]   ldr_be,
  input  logic [NCH-1:0]    ldr_ack,
  output logic [NCH-1:0]    ldr_done,
  output logic [15:0]       ldr_csum
);

  localparam int c_BPW = DW / 8;
  localparam int c_LB  = $clog2(c_BPW);
  localparam int c_LW  = (c_LB == 0) ? 1 : c_LB;
  localparam int c_CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FILL  = 2'd1;
  localparam logic [1:0] c_REQ   = 2'd2;
  localparam logic [1:0] c_DRAIN = 2'd3;

  logic [1:0]       r_state, w_next;
  logic             r_dl_q, r_ack_q;
  logic [c_CHW-1:0] r_ch;
  logic [DW-1:0]    r_wdat;
  logic [c_BPW-1:0] r_be;
  logic [AW-1:0]    r_addr;
  logic [NCH-1:0]   r_done;
  logic             r_held;
  logic [7:0]       r_held_byte;
  logic [c_LW-1:0]  r_held_lane;
  logic [AW-1:0]    r_held_addr;

  logic [c_LW-1:0]  w_lane;
  logic [AW-1:0]    w_waddr;
  logic [c_CHW-1:0] w_ch;
  logic [NCH-1:0]   w_sel;
  logic             w_in_range, w_start, w_ack_cur, w_ack_rise;
  logic             w_wr_ok, w_top, w_addr_miss;

  generate
    if (c_LB > 0) begin : g_lane
      assign w_lane = ioctl_addr[c_LB-1:0];
    end else begin : g_lane_single
      assign w_lane = '0;
    end
  endgenerate

  assign w_waddr     = AW'(ioctl_addr >> c_LB);
  assign w_ch        = c_CHW'(ioctl_index - 8'(CH_BASE));
  assign w_in_range  = (ioctl_index >= 8'(CH_BASE)) && ({1'b0, ioctl_index} < 9'(CH_BASE + NCH));
  assign w_start     = ioctl_download && !r_dl_q && w_in_range;
  assign w_sel       = NCH'(1) << r_ch;
  assign w_ack_cur   = |(ldr_ack & w_sel);
  // Only a fresh 0->1 ack completes a request; a level left high is ignored.
  assign w_ack_rise  = w_ack_cur && !r_ack_q;
  assign w_wr_ok     = (r_state == c_FILL) && ioctl_download && ioctl_wr;
  assign w_top       = (w_lane == c_LW'(c_BPW - 1));
  assign w_addr_miss = (r_be != '0) && (w_waddr != r_addr);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= c_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_start) w_next = c_FILL;
      c_FILL: begin
        if (!ioctl_download)                     w_next = c_DRAIN;
        else if (ioctl_wr && (w_addr_miss || w_top)) w_next = c_REQ;
      end
      c_REQ: begin
        if (w_ack_rise) begin
          if (r_held && (r_held_lane == c_LW'(c_BPW - 1))) w_next = c_REQ;
          else if (!ioctl_download)                         w_next = c_DRAIN;
          else                                              w_next = c_FILL;
        end
      end
      default: w_next = (r_be != '0) ? c_REQ : c_IDLE;
    endcase
  end

  always_comb begin
    ioctl_wait = 1'b0;
    ldr_wr     = '0;
    if (r_state == c_REQ) begin
      ioctl_wait = 1'b1;
      ldr_wr     = w_sel;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_q      <= 1'b1;
      r_ack_q     <= 1'b0;
      r_ch        <= '0;
      r_wdat      <= '0;
      r_be        <= '0;
      r_addr      <= '0;
      r_done      <= '0;
      r_held      <= 1'b0;
      r_held_byte <= '0;
      r_held_lane <= '0;
      r_held_addr <= '0;
    end else begin
      r_dl_q  <= ioctl_download;
      r_ack_q <= w_ack_cur;
      case (r_state)
        c_IDLE: begin
          if (w_start) begin
            r_ch   <= w_ch;
            r_done <= r_done & ~(NCH'(1) << w_ch);
            r_wdat <= '0;
            r_be   <= '0;
            r_held <= 1'b0;
          end
        end
        c_FILL: begin
          if (w_wr_ok) begin
            if (w_addr_miss) begin
              r_held      <= 1'b1;
              r_held_byte <= ioctl_dout;
              r_held_lane <= w_lane;
              r_held_addr <= w_waddr;
            end else begin
              r_addr <= w_waddr;
              for (int i = 0; i < c_BPW; i++) begin
                if (w_lane == c_LW'(i)) begin
                  r_wdat[i*8 +: 8] <= ioctl_dout;
                  r_be[i]          <= 1'b1;
                end
              end
            end
          end
        end
        c_REQ: begin
          if (w_ack_rise) begin
            r_be   <= '0;
            r_wdat <= '0;
            if (r_held) begin
              r_held <= 1'b0;
              r_addr <= r_held_addr;
              for (int i = 0; i < c_BPW; i++) begin
                if (r_held_lane == c_LW'(i)) begin
                  r_wdat[i*8 +: 8] <= r_held_byte;
                  r_be[i]          <= 1'b1;
                end
              end
            end
          end
        end
        default: begin
          if (r_be == '0) r_done <= r_done | w_sel;
        end
      endcase
    end
  end

  assign ldr_addr = r_addr;
  assign ldr_wdat = r_wdat;
  assign ldr_be   = r_be;
  assign ldr_done = r_done;

`ifdef LOADER_CSUM_EN
  logic [15:0] r_csum;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                            r_csum <= '0;
    else if (r_state == c_IDLE && w_start)   r_csum <= '0;
    else if (w_wr_ok)                        r_csum <= r_csum + 16'(ioctl_dout);
  end
  assign ldr_csum = r_csum;
`else
  assign ldr_csum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ioctl_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ioctl_loader : directed checks of ioctl_loader (DW=16, NCH=2)         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ioctl_loader;

`ifdef LOADER_CSUM_EN
  localparam bit c_CSUM_ON = 1'b1;
`else
  localparam bit c_CSUM_ON = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [1:0]  ldr_ack = '0;
  logic        ioctl_wait;
  logic [1:0]  ldr_wr;
  logic [19:0] ldr_addr;
  logic [15:0] ldr_wdat;
  logic [1:0]  ldr_be;
  logic [1:0]  ldr_done;
  logic [15:0] ldr_csum;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_sys = ~clk_sys;

  ioctl_loader #(.DW(16), .AW(20), .NCH(2), .CH_BASE(0)) u_dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .ldr_wr         (ldr_wr),
    .ldr_addr       (ldr_addr),
    .ldr_wdat       (ldr_wdat),
    .ldr_be         (ldr_be),
    .ldr_ack        (ldr_ack),
    .ldr_done       (ldr_done),
    .ldr_csum       (ldr_csum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic chk_req(input string tag, input logic [1:0] wr, input logic [19:0] a,
                         input logic [15:0] d, input logic [1:0] be);
    chk({tag, "_wr"},   ldr_wr,     wr);
    chk({tag, "_addr"}, ldr_addr,   a);
    chk({tag, "_wdat"}, ldr_wdat,   d);
    chk({tag, "_be"},   ldr_be,     be);
    chk({tag, "_wait"}, ioctl_wait, 1'b1);
  endtask

  initial begin
    tick(); tick();
    chk("rst_wr", ldr_wr, 0);       chk("rst_wait", ioctl_wait, 0);
    chk("rst_be", ldr_be, 0);       chk("rst_wdat", ldr_wdat, 0);
    chk("rst_addr", ldr_addr, 0);   chk("rst_done", ldr_done, 0);
    chk("rst_csum", ldr_csum, 0);
    reset_n = 1'b1;
    tick(); tick();

    // Full word on channel 1, ack three cycles into the request
    ioctl_index = 8'd1; ioctl_download = 1'b1; tick();
    wr_byte(25'd0, 8'h11); wr_byte(25'd1, 8'h22);
    chk_req("t1", 2'b10, 20'd0, 16'h2211, 2'b11);
    tick(); tick();
    chk("t1_hold_wait", ioctl_wait, 1); chk("t1_hold_wr", ldr_wr, 2'b10);
    ldr_ack = 2'b10; tick(); ldr_ack = 2'b00;
    chk("t1_wait_drop", ioctl_wait, 0); chk("t1_wr_drop", ldr_wr, 0);
    chk("t1_be_clr", ldr_be, 0);
    ioctl_download = 1'b0; tick(); tick();
    chk("t1_done", ldr_done, 2'b10);

    // Channel 0: full word then a partial word flushed by the download end
    ioctl_index = 8'd0; ioctl_download = 1'b1; tick();
    wr_byte(25'd4, 8'hAA); wr_byte(25'd5, 8'hBB);
    chk_req("t2a", 2'b01, 20'd2, 16'hBBAA, 2'b11);
    ldr_ack = 2'b01; tick(); ldr_ack = 2'b00;
    wr_byte(25'd6, 8'hCC);
    chk("t2_pend_be", ldr_be, 2'b01); chk("t2_pend_wr", ldr_wr, 0);
    ioctl_download = 1'b0; tick(); tick();
    chk_req("t2b", 2'b01, 20'd3, 16'h00CC, 2'b01);
    chk("t2_done_mid", ldr_done, 2'b10);
    ldr_ack = 2'b01; tick(); ldr_ack = 2'b00; tick();
    chk("t2_done", ldr_done, 2'b11);  // ch1 still set from the first download

    // Address jump: pending word flushed, jumped byte held; byte during wait dropped
    ioctl_download = 1'b1; tick();
    chk("t3_done_clr", ldr_done, 2'b10);
    wr_byte(25'd0, 8'h55); wr_byte(25'd8, 8'h66);
    chk_req("t3a", 2'b01, 20'd0, 16'h0055, 2'b01);
    wr_byte(25'd2, 8'h77);
    chk("t3_drop_wdat", ldr_wdat, 16'h0055);
    ldr_ack = 2'b10; tick();
    chk("t3_other_ack", ldr_wr, 2'b01);
    ldr_ack = 2'b01; tick(); ldr_ack = 2'b00;
    chk("t3_held_addr", ldr_addr, 20'd4); chk("t3_held_wdat", ldr_wdat, 16'h0066);
    chk("t3_held_be", ldr_be, 2'b01);     chk("t3_held_wait", ioctl_wait, 0);
    chk("t3_csum", ldr_csum, c_CSUM_ON ? 16'h00BB : 16'h0000);
    ioctl_download = 1'b0; tick(); tick();
    chk_req("t3b", 2'b01, 20'd4, 16'h0066, 2'b01);
    ldr_ack = 2'b01; tick(); ldr_ack = 2'b00; tick();
    chk("t3_done", ldr_done, 2'b11);

    // Out-of-range index: everything dropped
    ioctl_index = 8'd7; ioctl_download = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      wr_byte(25'(i), 8'h90 + 8'(i));
      chk("t4_wait", ioctl_wait, 0); chk("t4_wr", ldr_wr, 0);
    end
    ioctl_download = 1'b0; tick(); tick();
    chk("t4_done", ldr_done, 2'b11);
    chk("t4_csum", ldr_csum, c_CSUM_ON ? 16'h00BB : 16'h0000);

    // Reset in the middle of a request
    ioctl_index = 8'd0; ioctl_download = 1'b1; tick();
    wr_byte(25'd0, 8'h12); wr_byte(25'd1, 8'h34);
    chk("t5_wr_before", ldr_wr, 2'b01);
    reset_n = 1'b0; #1;
    chk("t5_rst_wr", ldr_wr, 0);     chk("t5_rst_wait", ioctl_wait, 0);
    chk("t5_rst_be", ldr_be, 0);     chk("t5_rst_wdat", ldr_wdat, 0);
    chk("t5_rst_addr", ldr_addr, 0); chk("t5_rst_done", ldr_done, 0);
    chk("t5_rst_csum", ldr_csum, 0);
    tick(); reset_n = 1'b1; tick(); tick();
    wr_byte(25'd2, 8'h56);
    chk("t5_no_accept_be", ldr_be, 0);
    ldr_ack = 2'b01; tick(); ldr_ack = 2'b00;
    chk("t5_no_write", ldr_wr, 0); chk("t5_no_wait", ioctl_wait, 0);
    ioctl_download = 1'b0; tick(); tick();
    chk("t5_done", ldr_done, 0);

    // 258 bytes of 0xFF on channel 1: 258*255 = 0x100FE wraps to 0x00FE
    ioctl_index = 8'd1; ioctl_download = 1'b1; tick();
    for (int k = 0; k < 129; k++) begin
      wr_byte(25'(2 * k), 8'hFF); wr_byte(25'(2 * k + 1), 8'hFF);
      ldr_ack = 2'b10; tick(); ldr_ack = 2'b00;
    end
    chk("t6_last_addr", ldr_addr, 20'd128);
    ioctl_download = 1'b0; tick(); tick();
    chk("t6_done", ldr_done, 2'b10);
    chk("t6_csum", ldr_csum, c_CSUM_ON ? 16'h00FE : 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
